// File: rtl/int_priority_ctrl.sv
// int_priority_ctrl: prioritised interrupt controller in front of the MCU
// control unit. It edge-detects the IRQ lines and latches each edge as
// pending. Pending bits are gated by an IO-writable mask, and the lowest
// eligible index is served, one request at a time. The controller owns the
// global interrupt-enable flag.
//
// Optional build macro IRQ_SYNC_EN: when it is defined, each IRQ bit passes
// through a 2-flop synchroniser before edge detection. IRQ may then be
// asynchronous, and latency to PENDING grows by 2 cycles.
//
// Ports:
//   CLK        system clock
//   RESET_N    synchronous reset, active-low
//   IRQ        peripheral interrupt lines (index 0 = highest priority)
//   I_SET      SEI/RETIE pulse, sets IE
//   I_CLR      CLI pulse, clears IE (wins over I_SET)
//   INT_ACK    MCU entered interrupt state
//   INT_DONE   MCU executed RETID/RETIE
//   IO_STRB    IO write strobe
//   PORT_ID    IO address (MASK_PORT = mask, CLR_PORT = write-1-to-clear)
//   OUT_PORT   IO write data
//   INT_R_MCU  interrupt request to control unit (registered)
//   INT_ID     index of source being served (registered)
//   PENDING    pending register, for IN readback
//   IE         global interrupt enable
module int_priority_ctrl #(
   parameter int unsigned NUM_SRC   = 8,
   parameter logic [7:0]  MASK_PORT = 8'hF0,
   parameter logic [7:0]  CLR_PORT  = 8'hF1
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [NUM_SRC-1:0] IRQ,
   input  logic               I_SET,
   input  logic               I_CLR,
   input  logic               INT_ACK,
   input  logic               INT_DONE,
   input  logic               IO_STRB,
   input  logic [7:0]         PORT_ID,
   input  logic [7:0]         OUT_PORT,
   output logic               INT_R_MCU,
   output logic [2:0]         INT_ID,
   output logic [NUM_SRC-1:0] PENDING,
   output logic               IE
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e             state_q;
   logic [NUM_SRC-1:0] irq_s;
   logic [NUM_SRC-1:0] irq_prev_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] pending_d;
   logic [NUM_SRC-1:0] mask_q;
   logic               ie_q;
   logic               ie_d;
   logic               int_r_q;
   logic [2:0]         int_id_q;

   logic [NUM_SRC-1:0] edge_det;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] sel_vec;
   logic [2:0]         win_id;
   logic               win_found;
   logic               take;
   logic               mask_wr;
   logic               clr_wr;

`ifdef IRQ_SYNC_EN
   // Two-stage synchroniser for asynchronous IRQ lines
   logic [NUM_SRC-1:0] sync1_q;
   logic [NUM_SRC-1:0] sync2_q;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= IRQ;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = IRQ;
`endif

   assign edge_det = irq_s & ~irq_prev_q;
   assign eligible = pending_q & mask_q;
   assign mask_wr  = IO_STRB && (PORT_ID == MASK_PORT);
   assign clr_wr   = IO_STRB && (PORT_ID == CLR_PORT);
   assign clr_vec  = clr_wr ? OUT_PORT[NUM_SRC-1:0] : '0;

   // Lowest eligible index wins
   always_comb begin
      win_id    = 3'd0;
      win_found = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (eligible[i] && !win_found) begin
            win_found = 1'b1;
            win_id    = 3'(i);
         end
      end
   end

   assign take = (state_q == ST_IDLE) && ie_q && win_found;

   always_comb begin
      sel_vec = '0;
      if (take) sel_vec[win_id] = 1'b1;
   end

   // A new edge beats a clear or a service in the same cycle
   assign pending_d = (pending_q & ~clr_vec & ~sel_vec) | edge_det;

   // I_CLR beats I_SET; accepting a request always drops IE
   always_comb begin
      ie_d = ie_q;
      if (I_SET) ie_d = 1'b1;
      if (I_CLR) ie_d = 1'b0;
      if (take)  ie_d = 1'b0;
   end

   // State register, pending/mask/IE and registered request outputs
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         irq_prev_q <= irq_s;
         pending_q  <= '0;
         mask_q     <= '0;
         ie_q       <= 1'b0;
         int_r_q    <= 1'b0;
         int_id_q   <= 3'd0;
      end else begin
         irq_prev_q <= irq_s;
         pending_q  <= pending_d;
         ie_q       <= ie_d;
         if (mask_wr) mask_q <= OUT_PORT[NUM_SRC-1:0];
         case (state_q)
            ST_IDLE: begin
               if (take) begin
                  state_q  <= ST_REQ;
                  int_r_q  <= 1'b1;
                  int_id_q <= win_id;
               end
            end
            ST_REQ: begin
               if (INT_ACK) begin
                  state_q <= ST_SERVICE;
                  int_r_q <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (INT_DONE) state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               int_r_q <= 1'b0;
            end
         endcase
      end
   end

   assign INT_R_MCU = int_r_q;
   assign INT_ID    = int_id_q;
   assign PENDING   = pending_q;
   assign IE        = ie_q;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed testbench for int_priority_ctrl (default build, IRQ used directly).
module tb_int_priority_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] IRQ;
   logic       I_SET, I_CLR, INT_ACK, INT_DONE, IO_STRB;
   logic [7:0] PORT_ID, OUT_PORT;
   logic       INT_R_MCU;
   logic [2:0] INT_ID;
   logic [7:0] PENDING;
   logic       IE;

   int n_checks = 0;
   int n_errors = 0;

   int_priority_ctrl dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IRQ       (IRQ),
      .I_SET     (I_SET),
      .I_CLR     (I_CLR),
      .INT_ACK   (INT_ACK),
      .INT_DONE  (INT_DONE),
      .IO_STRB   (IO_STRB),
      .PORT_ID   (PORT_ID),
      .OUT_PORT  (OUT_PORT),
      .INT_R_MCU (INT_R_MCU),
      .INT_ID    (INT_ID),
      .PENDING   (PENDING),
      .IE        (IE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1ns after it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      I_SET = 0; I_CLR = 0; INT_ACK = 0; INT_DONE = 0;
      IO_STRB = 0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
   endtask

   task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
      IO_STRB = 1; PORT_ID = port; OUT_PORT = data;
   endtask

   initial begin
      idle_inputs();
      RESET_N = 0;
      IRQ     = 8'h01;
      tick(); tick();

      // Reset then idle: held IRQ[0] must not look like an edge
      RESET_N = 1;
      tick();
      chk("rst_int_r", 32'(INT_R_MCU), 32'd0);
      chk("rst_pending", 32'(PENDING), 32'h00);
      chk("rst_ie", 32'(IE), 32'd0);
      chk("rst_int_id", 32'(INT_ID), 32'd0);
      tick();
      chk("rst_no_edge", 32'(PENDING), 32'h00);
      IRQ = 8'h00;
      tick();

      // Basic service
      io_wr(8'hF0, 8'hFF); I_SET = 1;
      tick();
      idle_inputs();
      chk("basic_ie_set", 32'(IE), 32'd1);
      IRQ = 8'h08;
      tick();
      chk("basic_pend_N", 32'(PENDING), 32'h08);
      chk("basic_req_N", 32'(INT_R_MCU), 32'd0);
      tick();
      chk("basic_req_N1", 32'(INT_R_MCU), 32'd1);
      chk("basic_id", 32'(INT_ID), 32'd3);
      chk("basic_pend_N1", 32'(PENDING), 32'h00);
      chk("basic_ie_clr", 32'(IE), 32'd0);
      tick();
      chk("basic_req_hold", 32'(INT_R_MCU), 32'd1);
      INT_ACK = 1;
      tick();
      idle_inputs();
      chk("basic_ack", 32'(INT_R_MCU), 32'd0);
      INT_DONE = 1;
      tick();
      idle_inputs();
      IRQ = 8'h00;
      tick();

      // Priority and queueing
      I_SET = 1;
      tick();
      idle_inputs();
      IRQ = 8'h24;
      tick();
      chk("prio_pend", 32'(PENDING), 32'h24);
      tick();
      chk("prio_req1", 32'(INT_R_MCU), 32'd1);
      chk("prio_id1", 32'(INT_ID), 32'd2);
      chk("prio_pend1", 32'(PENDING), 32'h20);
      INT_ACK = 1;
      tick();
      idle_inputs();
      tick();
      chk("prio_svc_pend", 32'(PENDING), 32'h20);
      chk("prio_svc_req", 32'(INT_R_MCU), 32'd0);
      INT_DONE = 1; I_SET = 1;
      tick();
      idle_inputs();
      chk("prio_done_req", 32'(INT_R_MCU), 32'd0);
      chk("prio_done_ie", 32'(IE), 32'd1);
      tick();
      chk("prio_req2", 32'(INT_R_MCU), 32'd1);
      chk("prio_id2", 32'(INT_ID), 32'd5);
      chk("prio_pend2", 32'(PENDING), 32'h00);
      INT_ACK = 1;
      tick();
      idle_inputs();
      INT_DONE = 1;
      tick();
      idle_inputs();
      IRQ = 8'h00;
      tick();

      // Masking
      io_wr(8'hF0, 8'hFE); I_SET = 1;
      tick();
      idle_inputs();
      IRQ = 8'h01;
      tick();
      chk("mask_pend", 32'(PENDING), 32'h01);
      tick();
      chk("mask_no_req", 32'(INT_R_MCU), 32'd0);
      chk("mask_pend_hold", 32'(PENDING), 32'h01);
      io_wr(8'hF0, 8'hFF);
      tick();
      idle_inputs();
      chk("mask_wr_edge", 32'(INT_R_MCU), 32'd0);
      tick();
      chk("unmask_req", 32'(INT_R_MCU), 32'd1);
      chk("unmask_id", 32'(INT_ID), 32'd0);
      INT_ACK = 1;
      tick();
      idle_inputs();
      INT_DONE = 1;
      tick();
      idle_inputs();
      IRQ = 8'h00;
      tick();

      // IE and clear conflicts
      I_SET = 1;
      tick();
      idle_inputs();
      chk("ie_set", 32'(IE), 32'd1);
      I_SET = 1; I_CLR = 1;
      tick();
      idle_inputs();
      chk("ie_clr_wins", 32'(IE), 32'd0);
      IRQ = 8'h04; io_wr(8'hF1, 8'h04);
      tick();
      idle_inputs();
      chk("set_beats_clr", 32'(PENDING), 32'h04);
      io_wr(8'hF1, 8'h04);
      tick();
      idle_inputs();
      chk("clr_port", 32'(PENDING), 32'h00);
      IRQ = 8'h00;
      tick();

      // Reset mid-service
      I_SET = 1;
      tick();
      idle_inputs();
      IRQ = 8'h11;
      tick();
      chk("mid_pend", 32'(PENDING), 32'h11);
      tick();
      chk("mid_req", 32'(INT_R_MCU), 32'd1);
      chk("mid_pend_left", 32'(PENDING), 32'h10);
      INT_ACK = 1;
      tick();
      idle_inputs();
      chk("mid_svc", 32'(INT_R_MCU), 32'd0);
      RESET_N = 0;
      tick();
      chk("mid_rst_pend", 32'(PENDING), 32'h00);
      chk("mid_rst_req", 32'(INT_R_MCU), 32'd0);
      chk("mid_rst_ie", 32'(IE), 32'd0);
      chk("mid_rst_id", 32'(INT_ID), 32'd0);
      RESET_N = 1; I_SET = 1; IRQ = 8'h00;
      tick();
      idle_inputs();
      IRQ = 8'h01;
      tick();
      chk("post_rst_pend", 32'(PENDING), 32'h01);
      tick();
      chk("post_rst_mask0", 32'(INT_R_MCU), 32'd0);
      chk("post_rst_ie", 32'(IE), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
